// File: rtl/bus_pkg.sv
// Shared types for the CPU data-bus responder: slave regions, FSM states and
// the one-hot select decode used when a request is accepted.
package bus_pkg;

    typedef enum logic [2:0] {REG_NONE, REG_ROM, REG_RAM, REG_IO, REG_GFX} region_t;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERROR} bus_state_t;

    localparam int BUS_BE_W = 4;

    // sel is {gfx, io, ram, rom}; anything other than exactly one bit maps to REG_NONE
    function automatic region_t decode_region(input logic [3:0] sel);
        case (sel)
            4'b0001: return REG_ROM;
            4'b0010: return REG_RAM;
            4'b0100: return REG_IO;
            4'b1000: return REG_GFX;
            default: return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Slave-ack watchdog: counts ACCESS cycles from zero and flags expiry on the
// LIMIT-th cycle of a single access.
module bus_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/bus_response_ctrl.sv
// Slave-side responder for the CPU data bus: strobes one slave per request and
// returns cpu_ack/cpu_err. Define BUS_TIMEOUT_EN to add the slave-ack watchdog.
//
// state    | meaning
// S_IDLE   | waiting for cpu_req; latches the request when it arrives
// S_ACCESS | strobe of cur_region held high until its ack (or watchdog expiry)
// S_DONE   | one-cycle cpu_ack, read data already captured
// S_ERROR  | one-cycle cpu_err with ERR_RDATA, no slave touched
module bus_response_ctrl
    import bus_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 32,
    parameter int                TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cpu_we,
    input  logic [BUS_BE_W-1:0] cpu_be,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic                rom_sel,
    input  logic                ram_sel,
    input  logic                io_sel,
    input  logic                gfx_sel,
    output logic                cpu_ack,
    output logic                cpu_err,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic [ADDR_W-1:0]   slv_addr,
    output logic                slv_we,
    output logic [BUS_BE_W-1:0] slv_be,
    output logic [DATA_W-1:0]   slv_wdata,
    output logic                rom_stb,
    output logic                ram_stb,
    output logic                io_stb,
    output logic                gfx_stb,
    input  logic [DATA_W-1:0]   rom_rdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    input  logic [DATA_W-1:0]   io_rdata,
    input  logic [DATA_W-1:0]   gfx_rdata,
    input  logic                rom_ack,
    input  logic                ram_ack,
    input  logic                io_ack,
    input  logic                gfx_ack
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    bus_state_t        state, state_nx;
    region_t           cur_region, req_region;
    logic              req_bad;
    logic              accept, enter_access, enter_err, capture;
    logic              region_ack;
    logic [DATA_W-1:0] region_rdata;
    logic              timeout_expired;

    assign req_region = decode_region({gfx_sel, io_sel, ram_sel, rom_sel});
    assign req_bad    = (req_region == REG_NONE) || (req_region == REG_ROM && cpu_we);

    // Only the addressed slave's ack/rdata matter; the rest are ignored here
    always_comb begin
        region_ack   = 1'b0;
        region_rdata = '0;
        case (cur_region)
            REG_ROM: begin region_ack = rom_ack; region_rdata = rom_rdata; end
            REG_RAM: begin region_ack = ram_ack; region_rdata = ram_rdata; end
            REG_IO:  begin region_ack = io_ack;  region_rdata = io_rdata;  end
            REG_GFX: begin region_ack = gfx_ack; region_rdata = gfx_rdata; end
            default: ;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    bus_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (enter_access),
        .run    (state == S_ACCESS),
        .expired(timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    accept   = 1'b1;
                    state_nx = req_bad ? S_ERROR : S_ACCESS;
                end
            end
            S_ACCESS: begin
                // an ack on the watchdog's last cycle still completes normally
                if (region_ack) begin
                    capture  = !slv_we;
                    state_nx = S_DONE;
                end else if (timeout_expired) begin
                    state_nx = S_ERROR;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERROR: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign enter_access = (state != S_ACCESS) && (state_nx == S_ACCESS);
    assign enter_err    = (state != S_ERROR)  && (state_nx == S_ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cur_region <= REG_NONE;
            slv_addr   <= '0;
            slv_we     <= 1'b0;
            slv_be     <= '0;
            slv_wdata  <= '0;
            cpu_rdata  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                slv_addr   <= cpu_addr;
                slv_we     <= cpu_we;
                slv_be     <= cpu_be;
                slv_wdata  <= cpu_wdata;
                cur_region <= req_bad ? REG_NONE : req_region;
            end
            if (enter_err) begin
                cpu_rdata <= ERR_RDATA;
            end else if (capture) begin
                cpu_rdata <= region_rdata;
            end
        end
    end

    assign rom_stb = (state == S_ACCESS) && (cur_region == REG_ROM);
    assign ram_stb = (state == S_ACCESS) && (cur_region == REG_RAM);
    assign io_stb  = (state == S_ACCESS) && (cur_region == REG_IO);
    assign gfx_stb = (state == S_ACCESS) && (cur_region == REG_GFX);
    assign cpu_ack = (state == S_DONE);
    assign cpu_err = (state == S_ERROR);

endmodule
